// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: issues ops to an external
// multiplier and divider, stalls EX while they run, and owns HI/LO.
// Optional annul support is compiled in when MULDIV_ANNUL_EN is defined.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        hold_i,
    input  logic        annul_i,
    output logic        stallreq,
    output logic        busy,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [3:0] LAT = 4'(MUL_LAT);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_sgn;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_sgn;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hi_nx;
    logic [31:0] lo_nx;
    logic        wr_hi;
    logic        wr_lo;
    logic        ld_mul;
    logic        ld_div;
    logic        stall_c;
    logic        start_c;
    logic        dannul_c;
    logic        annul;

`ifdef MULDIV_ANNUL_EN
    assign annul = annul_i;
`else
    logic unused_annul;
    assign unused_annul = annul_i;
    assign annul        = 1'b0;
`endif

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall_c  = 1'b0;
        start_c  = 1'b0;
        dannul_c = 1'b0;
        ld_mul   = 1'b0;
        ld_div   = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        hi_nx    = hi;
        lo_nx    = lo;
        case (state)
            IDLE: begin
                if (req_valid && !annul) begin
                    case (req_op)
                        OP_MULT, OP_MULTU: begin
                            stall_c  = 1'b1;
                            ld_mul   = 1'b1;
                            cnt_nx   = LAT;
                            state_nx = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            stall_c = 1'b1;
                            // Divide by zero never touches the divider or HI/LO.
                            if (src2 != '0) begin
                                ld_div   = 1'b1;
                                state_nx = DIV;
                            end else begin
                                state_nx = DONE;
                            end
                        end
                        OP_MTHI: begin
                            if (!hold_i) begin
                                wr_hi = 1'b1;
                                hi_nx = src1;
                            end
                        end
                        OP_MTLO: begin
                            if (!hold_i) begin
                                wr_lo = 1'b1;
                                lo_nx = src1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                stall_c = 1'b1;
                if (annul) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt <= 4'd1) begin
                    cnt_nx   = '0;
                    wr_hi    = 1'b1;
                    wr_lo    = 1'b1;
                    hi_nx    = mul_result[63:32];
                    lo_nx    = mul_result[31:0];
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DIV: begin
                stall_c = 1'b1;
                if (annul) begin
                    dannul_c = 1'b1;
                    state_nx = IDLE;
                end else begin
                    start_c = 1'b1;
                    if (div_ready) begin
                        wr_hi    = 1'b1;
                        wr_lo    = 1'b1;
                        hi_nx    = div_result[63:32];
                        lo_nx    = div_result[31:0];
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                // Parking here while held keeps the stalled EX op from re-issuing.
                if (annul || !hold_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_sgn <= 1'b0;
            div_a   <= '0;
            div_b   <= '0;
            div_sgn <= 1'b0;
        end else begin
            if (ld_mul) begin
                mul_a   <= src1;
                mul_b   <= src2;
                mul_sgn <= is_signed_op(req_op);
            end
            if (ld_div) begin
                div_a   <= src1;
                div_b   <= src2;
                div_sgn <= is_signed_op(req_op);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (wr_hi) begin
                hi <= hi_nx;
            end
            if (wr_lo) begin
                lo <= lo_nx;
            end
        end
    end

    // The request-cycle stall is combinational from inputs, so mask it in reset.
    assign stallreq   = stall_c & resetn;
    assign busy       = (state != IDLE);
    assign div_start  = start_c;
    assign div_annul  = dannul_c;
    assign mul_ina    = mul_a;
    assign mul_inb    = mul_b;
    assign mul_signed = mul_sgn;
    assign div_op1    = div_a;
    assign div_op2    = div_b;
    assign div_signed = div_sgn;
    assign hi_o       = hi;
    assign lo_o       = lo;

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2: multiplier latency in cycles, legal range 1..15.
REQ-002 SHALL have ports clk in 1, rising-edge clock; resetn in 1, asynchronous active-low reset.
REQ-003 SHALL have ports req_valid in 1, EX holds a HI/LO-class op; req_op in 3, 000 mult / 001 multu / 010 div / 011 divu / 100 mthi / 101 mtlo; src1, src2 in 32, rs/rt values.
REQ-004 SHALL have ports hold_i in 1, downstream stall (stall[3]); annul_i in 1, flush of the EX op.
REQ-005 SHALL have ports stallreq out 1, EX stall request; busy out 1, state != IDLE.
REQ-006 SHALL have ports mul_signed out 1; mul_ina, mul_inb out 32; mul_result in 64.
REQ-007 SHALL have ports div_start out 1; div_signed out 1; div_annul out 1; div_op1, div_op2 out 32; div_ready in 1; div_result in 64, {remainder, quotient}.
REQ-008 SHALL have ports hi_o, lo_o out 32, architectural HI/LO.

Function
REQ-009 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-010 IDLE: req_valid with mult/multu SHALL latch src1/src2 and signedness, load cnt=MUL_LAT, and go to MUL; stallreq=1 combinationally in this cycle.
REQ-011 IDLE: req_valid with div/divu and src2!=0 SHALL latch operands and go to DIV; stallreq=1.
REQ-012 IDLE: div/divu with src2==0 SHALL go directly to DONE, leave HI/LO unchanged, and keep the divider idle; stallreq=1 in the request cycle.
REQ-013 IDLE: mthi/mtlo with hold_i=0 SHALL write src1 to HI/LO at the clock edge, with no state change and stallreq=0; with hold_i=1, no write.
REQ-014 MUL: stallreq=1; mul_ina/mul_inb/mul_signed SHALL be driven from latched registers and stay stable; cnt decrements each cycle; at the edge ending the MUL_LAT-th MUL cycle SHALL write HI=mul_result[63:32], LO=mul_result[31:0], then go to DONE.
REQ-015 DIV: stallreq=1; div_start=1, div_op1/div_op2/div_signed driven from latched registers; when div_ready=1, at that edge SHALL write HI=div_result[63:32], LO=div_result[31:0], drop div_start next cycle, then go to DONE.
REQ-016 DONE: stallreq=0; if hold_i=0, SHALL go to IDLE next cycle; otherwise SHALL remain in DONE (so a stalled EX op is not re-issued).
REQ-017 Outside MUL/DIV: div_start=0, and mul/div operand outputs SHALL hold their last latched values.
REQ-018 Latency: mult SHALL assert stallreq for exactly 1+MUL_LAT cycles; div SHALL assert it for 1 + cycles until div_ready.
REQ-019 req_valid in MUL/DIV/DONE SHALL be ignored (it is the same held instruction).
REQ-020 SHALL write HI/LO at most once per op and never in DONE.

Reset
REQ-021 resetn low SHALL asynchronously force state=IDLE, cnt=0, hi_o=lo_o=0, latched operands=0, and all outputs 0 (stallreq, busy, div_start, div_annul, mul_signed, div_signed).
REQ-022 Reset mid-MUL/DIV SHALL abort with no HI/LO write; after release, SHALL accept a request on the first clock.

Configuration
REQ-023 Macro MULDIV_ANNUL_EN defined: annul_i=1 in MUL/DIV/DONE SHALL force IDLE next edge with no HI/LO write; in DIV it SHALL pulse div_annul=1 for that cycle and drop div_start; annul_i in IDLE SHALL suppress the request.
REQ-024 Macro MULDIV_ANNUL_EN undefined: annul_i SHALL be ignored and div_annul tied to 0.

Verification
REQ-025 mult 0xFFFFFFFF*2, MUL_LAT=2 -> stallreq high 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-026 div -7/2, div_ready after 33 cycles -> div_start high until ready, then HI=0xFFFFFFFF, LO=0xFFFFFFFD, DONE one cycle with stallreq=0.
REQ-027 divu 5/0 -> no div_start, HI/LO unchanged, stallreq high 1 cycle.
REQ-028 mthi 0x12345678 with hold_i=0 -> hi_o=0x12345678 next cycle; with hold_i=1 -> unchanged.
REQ-029 hold_i=1 for 3 cycles during DONE -> state stays DONE, no re-issue, single HI/LO write.
REQ-030 MULDIV_ANNUL_EN: annul_i in DIV cycle 5 -> div_annul pulse, IDLE next, HI/LO unchanged; resetn low mid-MUL -> all outputs 0 immediately.
